// File: rtl/pwm_capture.sv
`timescale 1ns/1ps
// pwm_capture: measures high time and period of an asynchronous PWM input,
// decodes a speed code from the high time and flags a missing-edge timeout.
module pwm_capture #(
  parameter int unsigned CNT_W       = 22,
  parameter int unsigned TIMEOUT_CYC = 2200000,
  parameter int unsigned TH1         = 325000,
  parameter int unsigned TH2         = 700000,
  parameter int unsigned TH3         = 800000,
  parameter int unsigned TH4         = 900000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_count,
  output logic [CNT_W-1:0] period_count,
  output logic [2:0]       speed_code,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] Th1Val     = CNT_W'(TH1);
  localparam logic [CNT_W-1:0] Th2Val     = CNT_W'(TH2);
  localparam logic [CNT_W-1:0] Th3Val     = CNT_W'(TH3);
  localparam logic [CNT_W-1:0] Th4Val     = CNT_W'(TH4);
  localparam logic [CNT_W-1:0] OneVal     = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StMeas, StStuck} state_e;

  state_e           state_q, state_d;
  logic             sync0_q, s_q, s_dly_q, rise_q;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] high_q, high_d, period_q, period_d;
  logic [CNT_W-1:0] per_inc, hi_inc;
  logic [2:0]       speed_q, speed_d;
  logic             valid_q, valid_d;

  function automatic logic [2:0] decode(input logic [CNT_W-1:0] hi);
    if (hi < Th1Val)      return 3'd0;
    else if (hi < Th2Val) return 3'd1;
    else if (hi < Th3Val) return 3'd2;
    else if (hi < Th4Val) return 3'd3;
    else                  return 3'd4;
  endfunction

  // rise_q is registered, so the FSM uses s_dly_q as the level aligned with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0_q <= 1'b0;
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync0_q <= pwm_in;
      s_q     <= sync0_q;
      s_dly_q <= s_q;
      rise_q  <= s_q & ~s_dly_q;
    end
  end

  assign per_inc = (per_cnt_q == TimeoutVal) ? per_cnt_q : per_cnt_q + OneVal;
  assign hi_inc  = (hi_cnt_q == TimeoutVal) ? hi_cnt_q : hi_cnt_q + OneVal;

  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    high_d    = high_q;
    period_d  = period_q;
    speed_d   = speed_q;
    valid_d   = 1'b0;
    unique case (state_q)
      StIdle, StMeas: begin
        if (rise_q) begin
          if (state_q == StMeas) begin
            period_d = per_cnt_q;
            high_d   = hi_cnt_q;
            speed_d  = decode(hi_cnt_q);
            valid_d  = 1'b1;
          end
          state_d   = StMeas;
          per_cnt_d = OneVal;
          hi_cnt_d  = OneVal;
        end else if (per_cnt_q == TimeoutVal) begin
          state_d  = StStuck;
          period_d = '0;
          valid_d  = 1'b1;
          high_d   = s_dly_q ? '1 : '0;
          speed_d  = s_dly_q ? 3'd7 : 3'd0;
        end else begin
          per_cnt_d = per_inc;
          if (state_q == StMeas && s_dly_q) hi_cnt_d = hi_inc;
        end
      end
      StStuck: begin
        // Only a fresh rising edge leaves STUCK; a plain fall keeps the stuck values.
        if (rise_q) begin
          state_d   = StMeas;
          per_cnt_d = OneVal;
          hi_cnt_d  = OneVal;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      high_q    <= '0;
      period_q  <= '0;
      speed_q   <= 3'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      high_q    <= high_d;
      period_q  <= period_d;
      speed_q   <= speed_d;
      valid_q   <= valid_d;
    end
  end

  assign high_count   = high_q;
  assign period_count = period_q;
  assign speed_code   = speed_q;
  assign meas_valid   = valid_q;
  assign timeout      = (state_q == StStuck);

endmodule

// File: tb/tb_pwm_capture.sv
`timescale 1ns/1ps
// Directed bench for pwm_capture with scaled-down timing parameters.
module tb_pwm_capture;

  localparam int unsigned CntW  = 10;
  localparam int unsigned ToCyc = 300;

  logic            clk = 1'b0;
  logic            reset;
  logic            pwm_in;
  logic [CntW-1:0] high_count, period_count;
  logic [2:0]      speed_code;
  logic            meas_valid, timeout;

  int checks = 0;
  int errors = 0;
  int n;

  typedef struct packed {int hi; int per; int code; int to;} meas_t;
  meas_t cap_q[$];
  meas_t exp_q[$];

  always #5 clk = ~clk;

  pwm_capture #(
    .CNT_W(CntW), .TIMEOUT_CYC(ToCyc), .TH1(32), .TH2(70), .TH3(80), .TH4(90)
  ) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .high_count(high_count),
    .period_count(period_count), .speed_code(speed_code), .meas_valid(meas_valid),
    .timeout(timeout)
  );

  always @(negedge clk)
    if (meas_valid === 1'b1)
      cap_q.push_back(meas_t'{int'(high_count), int'(period_count), int'(speed_code),
                              int'(timeout)});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One PWM period: rise after a posedge, fall hi edges later, next rise per edges later.
  task automatic drive(input int hi, input int per, input bit jit);
    int off;
    @(posedge clk);
    off = jit ? int'($urandom_range(9, 1)) : 5;
    #(off) pwm_in = 1'b1;
    repeat (hi) @(posedge clk);
    off = jit ? int'($urandom_range(9, 1)) : 5;
    #(off) pwm_in = 1'b0;
    repeat (per - hi - 1) @(posedge clk);
  endtask

  task automatic expect_m(input int hi, input int per, input int code, input int to);
    exp_q.push_back(meas_t'{hi, per, code, to});
  endtask

  task automatic rise_hold();
    @(posedge clk);
    #5 pwm_in = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag);
    chk({tag, ".count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      chk($sformatf("%s[%0d].high", tag, i), cap_q[i].hi, exp_q[i].hi);
      chk($sformatf("%s[%0d].period", tag, i), cap_q[i].per, exp_q[i].per);
      chk($sformatf("%s[%0d].speed", tag, i), cap_q[i].code, exp_q[i].code);
      chk($sformatf("%s[%0d].timeout", tag, i), cap_q[i].to, exp_q[i].to);
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".high"}, high_count, 0);
    chk({tag, ".period"}, period_count, 0);
    chk({tag, ".speed"}, speed_code, 0);
    chk({tag, ".valid"}, meas_valid, 0);
    chk({tag, ".timeout"}, timeout, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");

    // Held low from reset: timeout one edge after the counter reaches TIMEOUT_CYC.
    @(negedge clk) reset = 1'b0;
    n = 0;
    while (n < 400 && timeout !== 1'b1) begin
      @(posedge clk);
      #1 n++;
    end
    chk("stuck_low.cycle", n, ToCyc + 1);
    chk("stuck_low.valid", meas_valid, 1);
    chk("stuck_low.high", high_count, 0);
    chk("stuck_low.speed", speed_code, 0);
    chk("stuck_low.period", period_count, 0);
    @(posedge clk);
    #1 chk("stuck_low.valid_pulse", meas_valid, 0);
    cap_q.delete();

    // Clean PWM; first rise out of STUCK yields no measurement.
    repeat (3) begin drive(65, 256, 1'b0); expect_m(65, 256, 1, 0); end
    drive(75, 256, 1'b0); expect_m(75, 256, 2, 0);
    drive(85, 256, 1'b0); expect_m(85, 256, 3, 0);
    drive(95, 256, 1'b0); expect_m(95, 256, 4, 0);
    drive(5, 256, 1'b0);  expect_m(5, 256, 0, 0);
    rise_hold();
    compare("pwm");

    // Input stays high past the timeout.
    n = 0;
    while (n < 400 && timeout !== 1'b1) begin
      @(posedge clk);
      #1 n++;
    end
    chk("stuck_high.timeout", timeout, 1);
    @(posedge clk);
    #1 expect_m(1023, 0, 7, 1);
    compare("stuck_high");
    pwm_in = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("stuck_fall.high", high_count, 1023);
    chk("stuck_fall.speed", speed_code, 7);
    chk("stuck_fall.timeout", timeout, 1);
    chk("stuck_fall.no_valid", cap_q.size(), 0);

    // Minimum phases with jittered edges, then a period of exactly TIMEOUT_CYC.
    repeat (4) begin drive(2, 10, 1'b1); expect_m(2, 10, 0, 0); end
    drive(150, ToCyc, 1'b0); expect_m(150, ToCyc, 4, 0);
    rise_hold();
    compare("short_exact");
    chk("exact.timeout", timeout, 0);

    // Asynchronous reset mid-period.
    repeat (20) @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_reset_vals("async_reset");
    pwm_in = 1'b0;
    @(negedge clk) reset = 1'b0;
    cap_q.delete();
    drive(65, 256, 1'b0);
    chk("post_reset.first_none", cap_q.size(), 0);
    @(posedge clk);
    #5 pwm_in = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk);
      #1 chk($sformatf("latency.k+%0d", j), meas_valid, 0);
    end
    @(posedge clk);
    #1 chk("latency.k+3", meas_valid, 1);
    expect_m(65, 256, 1, 0);
    repeat (2) @(posedge clk);
    #1 compare("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
